// File: rtl/hunter_pkg.sv
// Shared definitions for the 16-way stream demultiplexer.
//   DEMUX_PORTS   number of destination ports
//   DEMUX_SEL_W   width of the destination index
//   demux_state_e occupancy of the two-entry skid buffer
//   sel_onehot    index -> one-hot port mask
package hunter_pkg;

  localparam int unsigned DEMUX_PORTS = 16;
  localparam int unsigned DEMUX_SEL_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } demux_state_e;

  function automatic logic [DEMUX_PORTS-1:0] sel_onehot(input logic [DEMUX_SEL_W-1:0] sel);
    sel_onehot = DEMUX_PORTS'(1) << sel;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer.
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     upstream beat offered
//   in_ready     registered; low only while both entries are occupied
//   in_data      upstream payload (W bits)
//   out_ready    downstream handshake completes for the head entry this cycle
//   out_valid_c  next-cycle head-valid (combinational, for registering downstream)
//   out_data_c   next-cycle head payload (combinational, for registering downstream)
module skid_buf #(
  parameter int unsigned W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         out_ready,
  output logic         out_valid_c,
  output logic [W-1:0] out_data_c
);
  import hunter_pkg::*;

  demux_state_e state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         in_ready_q, in_ready_d;
  logic         accept_c;
  logic         deliver_c;

  // State and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state and storage update
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    s_d       = s_q;
    accept_c  = in_valid & in_ready_q;
    deliver_c = out_ready & (state_q != EMPTY);
    case (state_q)
      EMPTY: begin
        if (accept_c) begin
          m_d     = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept_c && deliver_c) begin
          m_d = in_data;
        end else if (accept_c) begin
          s_d     = in_data;
          state_d = FULL;
        end else if (deliver_c) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Input is blocked here because in_ready_q is low
        if (deliver_c) begin
          m_d     = s_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Outputs derived from the next state so downstream flops line up with M
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_c = (state_d != EMPTY);
    out_data_c  = m_d;
  end

  assign in_ready = in_ready_q;

endmodule

// File: rtl/demux16_4_stream.sv
// Registered 1-to-16 stream demultiplexer with a two-entry skid buffer.
//   N            payload width (default 32)
//   clk, rst     clock, asynchronous active-high reset
//   in_valid/in_ready/in_sel/in_data   producer handshake; in_ready registered
//   out_valid    one-hot (or zero) pending-port mask, registered
//   out_ready    per-port consumer ready; only the addressed bit matters
//   out_data     shared payload bus, registered
//   beat_count   delivery counter, present only when DEMUX_STATS_EN is defined
module demux16_4_stream
  import hunter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEMUX_SEL_W-1:0] in_sel,
  input  logic [N-1:0]           in_data,
  output logic [DEMUX_PORTS-1:0] out_valid,
  input  logic [DEMUX_PORTS-1:0] out_ready,
  output logic [N-1:0]           out_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]            beat_count
`endif
);

  localparam int unsigned PW = N + DEMUX_SEL_W;

  logic [PW-1:0]          sb_in_c;
  logic [PW-1:0]          m_next_c;
  logic                   m_valid_next_c;
  logic                   deliver_c;
  logic [DEMUX_PORTS-1:0] out_valid_q, out_valid_d;
  logic [N-1:0]           out_data_q, out_data_d;

  assign sb_in_c = {in_sel, in_data};

  // Only the addressed port's ready can complete the handshake
  assign deliver_c = |(out_valid_q & out_ready);

  skid_buf #(
    .W (PW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (sb_in_c),
    .out_ready   (deliver_c),
    .out_valid_c (m_valid_next_c),
    .out_data_c  (m_next_c)
  );

  // Decode next head entry into the registered port mask and payload
  always_comb begin
    out_valid_d = '0;
    out_data_d  = m_next_c[N-1:0];
    if (m_valid_next_c) begin
      out_valid_d = sel_onehot(m_next_c[PW-1 -: DEMUX_SEL_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef DEMUX_STATS_EN
  logic [15:0] beat_count_q, beat_count_d;

  // Free-running delivery counter, wraps naturally
  always_comb begin
    beat_count_d = beat_count_q;
    if (deliver_c) begin
      beat_count_d = beat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_demux16_4_stream.sv
module tb_demux16_4_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_sel;
  logic [31:0] in_data;
  logic [15:0] out_valid;
  logic [15:0] out_ready;
  logic [31:0] out_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] beat_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  demux16_4_stream #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
`ifdef DEMUX_STATS_EN
    ,
    .beat_count (beat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [15:0] rdy;
    logic        e_rdy;
    logic [15:0] e_vld;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic [31:0] d, input logic [15:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 16'hFFFF);
    step();
    step();
    rst = 1'b0;
  endtask

  logic [35:0] q[$];
  logic [35:0] head;
  logic [15:0] exp_ov;
  int          accepted;
  int          delivered;
  int          cyc;
  logic        m_vld;
  logic [3:0]  m_sel;
  logic [31:0] m_dat;
  logic [15:0] m_rdy;
  logic        will_acc;
  logic        will_dlv;

  initial begin
    // Hand-computed vectors: inputs for one cycle, outputs seen after that edge
    tbl[0]  = '{1'b1, 4'd5,  32'hDEADBEEF, 16'hFFFF, 1'b1, 16'h0020, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,        16'hFFFF, 1'b1, 16'h0000, 32'h0};
    tbl[2]  = '{1'b1, 4'd2,  32'h0000_00A2, 16'hFFFB, 1'b1, 16'h0004, 32'h0000_00A2};
    tbl[3]  = '{1'b1, 4'd9,  32'h0000_00A9, 16'hFFFB, 1'b0, 16'h0004, 32'h0000_00A2};
    tbl[4]  = '{1'b1, 4'd12, 32'h0000_0BAD, 16'hFFFB, 1'b0, 16'h0004, 32'h0000_00A2};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,        16'hFFFF, 1'b1, 16'h0200, 32'h0000_00A9};
    tbl[6]  = '{1'b0, 4'd0,  32'h0,        16'h0000, 1'b1, 16'h0200, 32'h0000_00A9};
    tbl[7]  = '{1'b1, 4'd4,  32'h0000_0044, 16'hFFFF, 1'b1, 16'h0010, 32'h0000_0044};
    tbl[8]  = '{1'b1, 4'd4,  32'h0000_0045, 16'hFFFF, 1'b1, 16'h0010, 32'h0000_0045};
    tbl[9]  = '{1'b0, 4'd0,  32'h0,        16'hFFEF, 1'b1, 16'h0010, 32'h0000_0045};
    tbl[10] = '{1'b0, 4'd0,  32'h0,        16'h0010, 1'b1, 16'h0000, 32'h0};

    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 16'hFFFF);
    #7;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
`ifdef DEMUX_STATS_EN
    chk("reset_beat_count", 32'(beat_count), 32'd0);
`endif
    step();
    rst = 1'b0;

    // Back-to-back stream to every port
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'(i), 32'h1111_1111 * 32'(i), 16'hFFFF);
      step();
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), 32'(16'h0001 << i));
      chk("stream_out_data", out_data, 32'h1111_1111 * 32'(i));
    end
    drive(1'b0, 4'd0, 32'd0, 16'hFFFF);
    step();
    chk("stream_drained", 32'(out_valid), 32'd0);
`ifdef DEMUX_STATS_EN
    chk("stream_beat_count", 32'(beat_count), 32'd16);
`endif

    // Table: single beat, blocked port with skid, simultaneous accept/deliver
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].vld, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      step();
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld != 16'h0000)
        chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_data);
    end

    // Reset while FULL drops both held beats
    do_reset();
    drive(1'b1, 4'd3, 32'h0000_0033, 16'hFF77);
    step();
    chk("mid_full_m", 32'(out_valid), 32'h0008);
    drive(1'b1, 4'd7, 32'h0000_0077, 16'hFF77);
    step();
    chk("mid_full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 4'd0, 32'd0, 16'hFF77);
    rst = 1'b1;
    #1;
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
`ifdef DEMUX_STATS_EN
    chk("rst_full_beat_count", 32'(beat_count), 32'd0);
`endif
    out_ready = 16'hFFFF;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_delivery", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    end

    // Random scoreboard: bench-side FIFO of depth two
    q.delete();
    accepted  = 0;
    delivered = 0;
    cyc       = 0;
    while (accepted < 1000 && cyc < 20000) begin
      m_vld = ($urandom_range(0, 3) != 0);
      m_sel = ($urandom_range(0, 1) != 0) ? 4'd4 : 4'($urandom_range(0, 15));
      m_dat = $urandom();
      m_rdy = 16'($urandom() | $urandom());
      drive(m_vld, m_sel, m_dat, m_rdy);
      will_acc = m_vld && (q.size() < 2);
      will_dlv = 1'b0;
      if (q.size() > 0) begin
        head     = q[0];
        will_dlv = m_rdy[head[35:32]];
      end
      step();
      cyc++;
      if (will_dlv) begin
        void'(q.pop_front());
        delivered++;
      end
      if (will_acc) begin
        q.push_back({m_sel, m_dat});
        accepted++;
      end
      chk("sb_in_ready", 32'(in_ready), 32'(q.size() < 2));
      exp_ov = 16'h0000;
      if (q.size() > 0) begin
        head   = q[0];
        exp_ov = 16'h0001 << head[35:32];
      end
      chk("sb_out_valid", 32'(out_valid), 32'(exp_ov));
      if (q.size() > 0) chk("sb_out_data", out_data, head[31:0]);
    end
    chk("sb_accepted_beats", 32'(accepted), 32'd1000);
`ifdef DEMUX_STATS_EN
    chk("sb_beat_count", 32'(beat_count), 32'(delivered[15:0]));

    // Counter wrap: 65534 deliveries, then three more
    do_reset();
    for (int i = 0; i < 65534; i++) begin
      drive(1'b1, 4'(i), 32'(i), 16'hFFFF);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 16'hFFFF);
    step();
    chk("wrap_preload", 32'(beat_count), 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i), 32'(i), 16'hFFFF);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 16'hFFFF);
    step();
    chk("wrap_result", 32'(beat_count), 32'h0000_0001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/demux16_4_stream.md
# demux16_4_stream

Registered 1-to-16 stream demultiplexer: accepts one beat of `N`-bit data plus a 4-bit destination index over a valid/ready handshake, and delivers it to exactly one of 16 destination ports, each with its own valid/ready pair. It is the distribution-side counterpart of the 16:1 select path, used where one producer (e.g. the load/store return path) feeds up to 16 independent consumers. It includes a two-entry skid buffer so that every output, including `in_ready`, is driven from a flop.

## Interface
- `N`, default 32: data width in bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  block can accept a beat; registered.
- `in_sel`  in  4  destination index 0..15, sampled with `in_data`.
- `in_data`  in  N  payload.
- `out_valid`  out  16  one-hot or zero; bit k = beat pending for port k.
- `out_ready`  in  16  per-port consumer ready.
- `out_data`  out  N  shared payload bus, meaningful only to the port whose `out_valid` bit is set.
- `beat_count`  out  16  present only with `DEMUX_STATS_EN` (see Configuration).

## Operation
- Accept: `in_valid & in_ready` at a rising edge. Deliver: `out_valid[k] & out_ready[k]`, where k is the held index.
- Storage: main register M (drives outputs) and skid register S, each holding {sel, data}.
- States: EMPTY (M, S empty), BUSY (M full), FULL (M and S full).
- EMPTY: `in_ready`=1; accept -> load M, go BUSY.
- BUSY: `in_ready`=1. Accept only -> load S, go FULL. Deliver only -> EMPTY. Accept and deliver -> load M with the new beat, stay BUSY.
- FULL: `in_ready`=0; input ignored. Deliver -> move S into M, go BUSY.
- `out_valid` = one-hot decode of M.sel when M is full, else 16'h0000. Bits of `out_ready` other than k are ignored.
- Beats are delivered in acceptance order. A blocked port stalls all later beats, including beats for other ports; no reordering.
- Data and sel pass through unmodified; no width conversion.

## Timing
- Reset (async assert, sync deassert by the system): state EMPTY, `in_ready`=1, `out_valid`=0, `out_data`=0, `beat_count`=0. In-flight beats are dropped; no partial delivery after reset.
- Latency: a beat accepted at edge t appears on `out_valid`/`out_data` after edge t (one cycle), when M was free or delivering at t.
- Sustained throughput: 1 beat/cycle while the addressed consumer holds ready.
- `in_ready` falls only in the cycle after a transition to FULL, so a beat offered while `in_ready` was 1 is always captured (skid).
- `out_valid` and `out_data` stay stable until delivered; no retraction.

## Configuration
- `DEMUX_STATS_EN` defined: adds the `beat_count` port, a 16-bit register that increments on every delivery and wraps from 16'hFFFF to 16'h0000. Reset value 0.
- Undefined: the port and register are absent. Datapath behaviour is identical.

## Structure
- Shared package `hunter_pkg`: `DEMUX_PORTS`=16, `DEMUX_SEL_W`=4, and the state enum {EMPTY, BUSY, FULL}.
- One sub-module: `skid_buf`, a generic two-entry valid/ready skid buffer parameterised on width (here N+4). The top level adds the one-hot decode, the per-port ready selection, and the optional counter.

## Test plan
- Reset mid-FULL (M.sel=3, S.sel=7 held) -> next cycle `out_valid`=0, `in_ready`=1, `beat_count`=0; neither beat is later delivered.
- Single beat sel=5, data=32'hDEADBEEF, all `out_ready`=1 -> one cycle later `out_valid`=16'h0020 with data; on the next edge `out_valid`=0.
- Stream sel=0,1,…,15 back to back, all ready -> 16 consecutive one-hot outputs 16'h0001…16'h8000, `in_ready` constantly 1, `beat_count`=16.
- `out_ready[2]`=0, push sel=2 then sel=9 -> FULL, `in_ready`=0, the sel=9 beat is held; raise `out_ready[2]` -> port 2 then port 9 delivered in order, `in_ready` returns to 1.
- Simultaneous accept and deliver in BUSY (sel 4 delivered while sel 4 accepted) -> stays BUSY, no loss or duplication; check via data scoreboard over 1000 random beats with random `out_ready`.
- With `DEMUX_STATS_EN`, preload count to 16'hFFFE via 65534 deliveries, then 3 more -> `beat_count`=16'h0001.
